// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit register value to a byte, half or word
// store and writes it to a byte-wide memory port, one byte per cycle. It also
// flags when the stored field no longer sign-extends back to the register.
module store_narrow_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [1:0]        size_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  input  logic              mem_ready_i,
  output logic              done_o,
  output logic              err_o,
  output logic              trunc_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  // Byte of the stored field that goes out at position idx; big-endian mode
  // sends the most significant byte of the field to the lowest address.
  function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [1:0]  last);
    logic [1:0] lane;
    lane = BIG_ENDIAN ? (last - idx) : idx;
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  // A narrowed value is lossless only when every bit above the field's sign
  // bit equals that sign bit (all zeros or all ones).
  function automatic logic narrow_lost(input logic [31:0] word,
                                       input logic [1:0]  size);
    case (size)
      2'b00:   return !((&word[31:7])  || !(|word[31:7]));
      2'b01:   return !((&word[31:15]) || !(|word[31:15]));
      default: return 1'b0;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          last_q, last_d;
  logic                trunc_q, trunc_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_data_q, mem_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                bad_req_s;

  // Next-state, datapath and next-cycle output computation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    last_d     = last_q;
    trunc_d    = trunc_q;
    we_d       = 1'b0;
    mem_addr_d = '0;
    mem_data_d = 8'h00;
    done_d     = 1'b0;
    err_d      = 1'b0;
    bad_req_s  = (size_i == 2'b11) ||
                 ((size_i == 2'b01) && addr_i[0]) ||
                 ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (bad_req_s) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            trunc_d = 1'b0;
          end else begin
            state_d    = ST_WRITE;
            addr_d     = addr_i;
            data_d     = data_i;
            idx_d      = 2'd0;
            last_d     = (size_i == 2'b00) ? 2'd0 :
                         (size_i == 2'b01) ? 2'd1 : 2'd3;
            trunc_d    = narrow_lost(data_i, size_i);
            we_d       = 1'b1;
            mem_addr_d = addr_i;
            mem_data_d = pick_byte(data_i, 2'd0, last_d);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (mem_ready_i) begin
          if (idx_q == last_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_q + 2'd1;
            we_d       = 1'b1;
            mem_addr_d = addr_q + {{(ADDR_W-2){1'b0}}, idx_d};
            mem_data_d = pick_byte(data_q, idx_d, last_q);
          end
        end else begin
          we_d       = 1'b1;
          mem_addr_d = mem_addr_q;
          mem_data_d = mem_data_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State, latched request and registered outputs; reset aborts any store.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= 32'h0000_0000;
      idx_q      <= 2'd0;
      last_q     <= 2'd0;
      trunc_q    <= 1'b0;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      trunc_q    <= trunc_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign trunc_o     = trunc_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: little- and big-endian instances share the
// same stimulus; a transaction-level model predicts every cycle's outputs.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] addr;
  logic [31:0] data;
  logic [1:0]  size;
  logic        mem_ready;

  logic        rdy_le, we_le, done_le, err_le, trunc_le;
  logic [31:0] maddr_le;
  logic [7:0]  mdata_le;
  logic        rdy_be, we_be, done_be, err_be, trunc_be;
  logic [31:0] maddr_be;
  logic [7:0]  mdata_be;

  int   total = 0;
  int   bad   = 0;
  logic exp_trunc;

  always #5 clk = ~clk;

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0)) u_le (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy_le),
    .addr_i(addr), .data_i(data), .size_i(size), .mem_we_o(we_le),
    .mem_addr_o(maddr_le), .mem_data_o(mdata_le), .mem_ready_i(mem_ready),
    .done_o(done_le), .err_o(err_le), .trunc_o(trunc_le)
  );

  store_narrow_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) u_be (
    .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(rdy_be),
    .addr_i(addr), .data_i(data), .size_i(size), .mem_we_o(we_be),
    .mem_addr_o(maddr_be), .mem_data_o(mdata_be), .mem_ready_i(mem_ready),
    .done_o(done_be), .err_o(err_be), .trunc_o(trunc_be)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare every output of both instances with the expected cycle view.
  task automatic outs(input string tag, input logic we, input logic [31:0] a,
                      input logic [7:0] dle, input logic [7:0] dbe,
                      input logic done, input logic err, input logic rdy);
    chk({tag, ".we_le"},    we_le,    we);
    chk({tag, ".addr_le"},  maddr_le, a);
    chk({tag, ".data_le"},  mdata_le, dle);
    chk({tag, ".done_le"},  done_le,  done);
    chk({tag, ".err_le"},   err_le,   err);
    chk({tag, ".rdy_le"},   rdy_le,   rdy);
    chk({tag, ".trunc_le"}, trunc_le, exp_trunc);
    chk({tag, ".we_be"},    we_be,    we);
    chk({tag, ".addr_be"},  maddr_be, a);
    chk({tag, ".data_be"},  mdata_be, dbe);
    chk({tag, ".done_be"},  done_be,  done);
    chk({tag, ".err_be"},   err_be,   err);
    chk({tag, ".rdy_be"},   rdy_be,   rdy);
    chk({tag, ".trunc_be"}, trunc_be, exp_trunc);
  endtask

  // Inputs other than the handshake are don't-care while busy; wiggle them.
  task automatic scramble();
    req_valid = 1'($urandom % 2);
    addr      = $urandom;
    data      = $urandom;
    size      = 2'($urandom % 4);
  endtask

  // One store from idle to idle; entered and left on a falling edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input int max_stall, input int first_stall);
    logic        bad_req;
    logic        new_trunc;
    logic [31:0] sext;
    logic [31:0] ea;
    logic [7:0]  dle, dbe;
    int          n, stalls;
    req_valid = 1'b1;
    addr      = a;
    data      = d;
    size      = sz;
    mem_ready = 1'($urandom % 2);
    outs("idle", 1'b0, 32'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    bad_req = (sz == 2'd3) || ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0));
    n = 1 << sz;
    if (sz == 2'd0)      sext = {{24{d[7]}}, d[7:0]};
    else if (sz == 2'd1) sext = {{16{d[15]}}, d[15:0]};
    else                 sext = d;
    new_trunc = bad_req ? 1'b0 : (sext != d);
    @(posedge clk);
    exp_trunc = new_trunc;
    @(negedge clk);
    scramble();
    if (bad_req) begin
      outs("err", 1'b0, 32'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end else begin
      for (int k = 0; k < n; k++) begin
        ea  = a + k;
        dle = d[8*k +: 8];
        dbe = d[8*(n-1-k) +: 8];
        stalls = ((k == 0) ? first_stall : 0) + $urandom_range(max_stall, 0);
        for (int s = 0; s < stalls; s++) begin
          mem_ready = 1'b0;
          outs("stall", 1'b1, ea, dle, dbe, 1'b0, 1'b0, 1'b0);
          @(posedge clk);
          @(negedge clk);
          scramble();
        end
        mem_ready = 1'b1;
        outs("write", 1'b1, ea, dle, dbe, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        scramble();
      end
      mem_ready = 1'($urandom % 2);
      outs("done", 1'b0, 32'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    outs("back", 1'b0, 32'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [1:0]  rs;
    rst_n = 1'b0; req_valid = 1'b0; addr = 32'd0; data = 32'd0; size = 2'd0;
    mem_ready = 1'b0; exp_trunc = 1'b0;
    repeat (2) @(negedge clk);
    outs("reset", 1'b0, 32'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    store(32'h0000_0100, 32'h1122_3344, 2'b10, 0, 0);
    store(32'h0000_0202, 32'hFFFF_8001, 2'b01, 0, 2);
    store(32'h0000_0055, 32'h0000_0180, 2'b00, 0, 0);
    chk("trunc_byte_lost", trunc_le, 32'd1);
    store(32'h0000_0056, 32'hFFFF_FF80, 2'b00, 0, 0);
    chk("trunc_byte_ok", trunc_le, 32'd0);
    store(32'h0000_0201, 32'h0000_1234, 2'b01, 0, 0);
    store(32'h0000_0010, 32'h0000_0001, 2'b11, 0, 0);
    store(32'h0000_0020, 32'h0001_0000, 2'b01, 0, 0);
    store(32'hFFFF_FFFC, 32'hA1B2_C3D4, 2'b10, 0, 0);
    store(32'hFFFF_FFFE, 32'h0000_1234, 2'b01, 0, 0);

    // Reset in the middle of a word store.
    req_valid = 1'b1; addr = 32'h0000_0300; data = 32'hDEAD_BEEF; size = 2'b10;
    mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    outs("rst_b0", 1'b1, 32'h0000_0300, 8'hEF, 8'hDE, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    outs("rst_b1", 1'b1, 32'h0000_0301, 8'hBE, 8'hAD, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_trunc = 1'b0;
    outs("rst_mid", 1'b0, 32'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      outs("rst_hold", 1'b0, 32'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    end
    rst_n = 1'b1;
    @(negedge clk);
    outs("rst_after", 1'b0, 32'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);

    // Randomized stores.
    for (int i = 0; i < 300; i++) begin
      rs = 2'($urandom % 4);
      ra = $urandom;
      if (($urandom % 4) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'd0;
      end
      if (($urandom % 8) == 0) ra[31:4] = 28'hFFF_FFFF;
      case ($urandom % 4)
        0:       rd = $urandom;
        1:       begin rd = $urandom; rd[31:8]  = {24{rd[7]}};  end
        2:       begin rd = $urandom; rd[31:16] = {16{rd[15]}}; end
        default: rd = $urandom % 512;
      endcase
      store(ra, rd, rs, 2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
